// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants and kind codes.
// The main decoder imports the same package.
package instr_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_JR   = 4'd5,
    K_LW   = 4'd6,
    K_SW   = 4'd7,
    K_BEQ  = 4'd8,
    K_ADDI = 4'd9,
    K_J    = 4'd10,
    K_JAL  = 4'd11
  } kind_t;

  typedef enum logic {
    ST_RUN,
    ST_FULL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_JR  = 6'h08;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: kind code plus fields -> 32-bit MIPS word.
// Fields a format does not use are forced to zero.
module instr_field_pack
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD};
      K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB};
      K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND};
      K_OR:    word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR};
      K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      K_JR:    word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
      K_LW:    word = {OP_LW, rs, rt, imm};
      K_SW:    word = {OP_SW, rs, rt, imm};
      K_BEQ:   word = {OP_BEQ, rs, rt, imm};
      K_ADDI:  word = {OP_ADDI, rs, rt, imm};
      K_J:     word = {OP_J, target};
      K_JAL:   word = {OP_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one registered output stage with valid/ready,
// sequential word addresses, RUN/FULL state and sticky full/err flags.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int          n    = 32,
  parameter int          AW   = 8,
  parameter int unsigned BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_instr,
  output logic [AW-1:0] out_addr,
  output logic          full,
  output logic          err
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

  state_t        state_q, state_d;
  logic          valid_q, valid_d;
  logic [n-1:0]  instr_q, instr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic          err_q, err_d;

  logic [31:0]   packed_word;
  logic          packed_illegal;
  logic          accept;
  logic          xfer;

  instr_field_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    full_d   = full_q;
    err_d    = err_q;
    in_ready = (state_q == ST_RUN) && (!valid_q || out_ready) && !restart;
    accept   = in_valid && in_ready;
    xfer     = valid_q && out_ready;

    if (restart) begin
      state_d = ST_RUN;
      valid_d = 1'b0;
      addr_d  = BASE_ADDR;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (xfer) begin
        valid_d = 1'b0;
        addr_d  = addr_q + AW'(1);
        if (addr_q == '1) begin
          full_d  = 1'b1;
          state_d = ST_FULL;
        end
      end
      // A same-cycle accept overrides the drain, keeping throughput at one word per cycle.
      if (accept) begin
        if (packed_illegal) begin
          err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          instr_d = packed_word;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed examples, randomized traffic
// against a behavioural model, and an AW=2 instance for wrap/full/restart.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart, in_valid, out_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, out_valid, full, err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;

  logic        s_reset, s_restart, s_in_valid, s_out_ready;
  logic [3:0]  s_in_kind;
  logic [4:0]  s_in_rs, s_in_rt, s_in_rd;
  logic [15:0] s_in_imm;
  logic [25:0] s_in_target;
  logic        s_in_ready, s_out_valid, s_full, s_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_out_addr;

  instr_encoder #(.n(32), .AW(8), .BASE(0)) dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .full(full), .err(err)
  );

  instr_encoder #(.n(32), .AW(2), .BASE(0)) dut_small (
    .clk(clk), .reset(s_reset), .restart(s_restart), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_kind(s_in_kind), .in_rs(s_in_rs), .in_rt(s_in_rt), .in_rd(s_in_rd), .in_imm(s_in_imm),
    .in_target(s_in_target), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_addr(s_out_addr), .full(s_full), .err(s_err)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the AW=8 instance
  bit          m_valid, m_full, m_err, m_run;
  logic [31:0] m_word;
  int          m_addr;

  function automatic logic [31:0] ref_encode(int kind, int rs, int rt, int rd, int imm, int target);
    longint unsigned w;
    int funct_tbl[5] = '{32, 34, 36, 37, 42};
    int op_tbl[4]    = '{35, 43, 4, 8};
    w = 0;
    if (kind <= 4)
      w = longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + longint'(rd) * (1 << 11) + funct_tbl[kind];
    else if (kind == 5)
      w = longint'(rs) * (1 << 21) + 8;
    else if (kind <= 9)
      w = longint'(op_tbl[kind - 6]) * (1 << 26) + longint'(rs) * (1 << 21) + longint'(rt) * (1 << 16) + imm;
    else if (kind <= 11)
      w = longint'(kind - 8) * (1 << 26) + target;
    return w[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_full = 0; m_err = 0; m_run = 1; m_addr = 0; m_word = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_addr", 32'(out_addr), m_addr);
    check("full", 32'(full), 32'(m_full));
    check("err", 32'(err), 32'(m_err));
    if (m_valid) check("out_instr", out_instr, m_word);
  endtask

  task automatic set_req(input bit v, input int kind, input int rs, input int rt,
                         input int rd, input int imm, input int target);
    in_valid  = v;
    in_kind   = 4'(kind);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 16'(imm);
    in_target = 26'(target);
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic tick();
    bit rdy, acc, xf;
    #1;
    rdy = m_run && (!m_valid || out_ready) && !restart;
    check("in_ready", 32'(in_ready), 32'(rdy));
    if (restart) begin
      model_reset();
    end else begin
      xf  = m_valid && out_ready;
      acc = in_valid && rdy;
      if (xf) begin
        m_valid = 0;
        if (m_addr == 255) begin
          m_addr = 0; m_full = 1; m_run = 0;
        end else begin
          m_addr++;
        end
      end
      if (acc) begin
        if (in_kind > 11) m_err = 1;
        else begin
          m_valid = 1;
          m_word  = ref_encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic s_set(input bit v, input int kind, input int rs, input int rt, input int imm);
    s_in_valid = v; s_in_kind = 4'(kind); s_in_rs = 5'(rs); s_in_rt = 5'(rt);
    s_in_rd = '0; s_in_imm = 16'(imm); s_in_target = '0;
  endtask

  initial begin
    reset = 1; restart = 0; out_ready = 0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    s_reset = 1; s_restart = 0; s_out_ready = 0;
    s_set(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 0; s_reset = 0;

    // ADD after reset
    out_ready = 1;
    set_req(1, 0, 1, 2, 3, 0, 0);
    tick();
    check("add_word", out_instr, 32'h00221820);
    check("add_addr", 32'(out_addr), 32'd0);
    set_req(0, 0, 0, 0, 0, 0, 0);
    tick();
    restart = 1;
    tick();
    restart = 0;
    check("restart_addr", 32'(out_addr), 32'd0);

    // Back-to-back LW / SW / JR
    set_req(1, 6, 29, 8, 0, 4, 0);
    tick();
    check("lw_word", out_instr, 32'h8FA80004);
    check("lw_addr", 32'(out_addr), 32'd0);
    set_req(1, 7, 29, 8, 0, 4, 0);
    tick();
    check("sw_word", out_instr, 32'hAFA80004);
    check("sw_addr", 32'(out_addr), 32'd1);
    set_req(1, 5, 31, 7, 9, 1234, 55);
    tick();
    check("jr_word", out_instr, 32'h03E00008);
    check("jr_addr", 32'(out_addr), 32'd2);
    set_req(0, 0, 0, 0, 0, 0, 0);
    tick();

    // BEQ held under backpressure
    out_ready = 0;
    set_req(1, 8, 1, 2, 0, 16'hFFFF, 0);
    tick();
    set_req(1, 0, 4, 5, 6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("beq_held", out_instr, 32'h1022FFFF);
      check("beq_in_ready", 32'(in_ready), 32'd0);
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1;
    tick();
    check("beq_drained", 32'(out_valid), 32'd0);

    // J, JAL, illegal kind
    set_req(1, 10, 3, 3, 3, 3, 26'h40);
    tick();
    check("j_word", out_instr, 32'h08000040);
    set_req(1, 11, 0, 0, 0, 0, 26'h40);
    tick();
    check("jal_word", out_instr, 32'h0C000040);
    set_req(1, 13, 1, 1, 1, 1, 1);
    tick();
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_no_word", 32'(out_valid), 32'd0);
    set_req(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int k;
      k = ($urandom % 8 == 0) ? 12 + int'($urandom % 4) : int'($urandom % 12);
      set_req($urandom % 4 != 0, k, $urandom % 32, $urandom % 32, $urandom % 32,
              $urandom % 65536, $urandom % (1 << 26));
      out_ready = ($urandom % 4 != 0);
      restart   = ($urandom % 700 == 0);
      tick();
    end
    restart = 0;

    // Asynchronous reset with a held word
    restart = 1;
    tick();
    restart = 0;
    out_ready = 0;
    set_req(1, 9, 0, 1, 0, 5, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3;
    reset = 1;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    model_reset();
    check_outputs();
    #1;
    reset = 0;

    // AW=2 instance: illegal kind, then fill the address space
    @(posedge clk); #1;
    s_out_ready = 1;
    s_set(1, 13, 0, 0, 0);
    @(posedge clk); #1;
    check("small_err", 32'(s_err), 32'd1);
    check("small_err_addr", 32'(s_out_addr), 32'd0);
    s_set(1, 9, 0, 1, 5);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("small_word", s_out_instr, 32'h20010005);
      check("small_addr", 32'(s_out_addr), i);
      check("small_full_pre", 32'(s_full), 32'd0);
    end
    s_set(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    s_set(1, 9, 0, 1, 5);
    #1;
    check("small_full", 32'(s_full), 32'd1);
    check("small_wrap_addr", 32'(s_out_addr), 32'd0);
    check("small_full_in_ready", 32'(s_in_ready), 32'd0);
    @(posedge clk); #1;
    check("small_full_no_accept", 32'(s_out_valid), 32'd0);
    s_set(0, 0, 0, 0, 0);
    s_restart = 1;
    @(posedge clk); #1;
    s_restart = 0;
    #1;
    check("small_restart_addr", 32'(s_out_addr), 32'd0);
    check("small_restart_full", 32'(s_full), 32'd0);
    check("small_restart_err", 32'(s_err), 32'd0);
    check("small_restart_in_ready", 32'(s_in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
